// File: rtl/sample_capture_buf_pkg.sv
// Shared definitions for the sample capture buffer.
// Holds the capture FSM state encoding, the restart-type constants that the
// measurement controller uses to request a flush (REDO/RECONFIG/CLOSE), and
// the default sample width.
package sample_capture_buf_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  localparam int STATE_NUM = 3;
  localparam int STATE_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Restart types issued by the controller; any of them produces a clear pulse.
  typedef enum logic [1:0] {
    RESTART_REDO     = 2'd0,
    RESTART_RECONFIG = 2'd1,
    RESTART_CLOSE    = 2'd2
  } restart_t;

endpackage

// File: rtl/sample_capture_buf_ram.sv
// Sample storage for the capture buffer.
// Simple dual-port RAM: one synchronous write port, one combinational read
// port. No reset on the array; the pointers in the parent define validity.
// Ports:
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address
//   rd_data  - read data (combinational from rd_addr)
module sample_ram
  import sample_capture_buf_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_capture_buf.sv
// Capture buffer downstream of the measurement controller.
// Stores every accepted sample during execute, then drains them in order over
// a valid/ready stream once drain_en (the controller's finish_op) is high.
// Ports:
//   clk, rstn                        - clock, synchronous active-low reset
//   clear                            - synchronous flush (restart pulse)
//   wr_data, wr_vld                  - incoming samples
//   drain_en                         - readout permitted
//   rd_data, rd_vld, rd_rdy, rd_last - readout stream, rd_last on final word
//   level, full, empty               - words written and not yet read out
//   drain_done                       - pulse after the rd_last transfer
//   event_wr_when_full               - pulse: write attempted while full
//   event_rd_rdy_when_not_draining   - pulse: rd_rdy while drain_en low
module sample_capture_buf
  import sample_capture_buf_pkg::*;
#(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_vld,
  input  logic                  drain_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_vld,
  input  logic                  rd_rdy,
  output logic                  rd_last,
  output logic [CNT_WIDTH-1:0]  level,
  output logic                  full,
  output logic                  empty,
  output logic                  drain_done,
  output logic                  event_wr_when_full,
  output logic                  event_rd_rdy_when_not_draining
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0]  level_q;
  logic [CNT_WIDTH-1:0]  mem_count;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [DATA_WIDTH-1:0] ostage_p1;
  logic                  vld_p1;
  logic                  last_p1;
  logic                  done_p1;
  logic                  evf_p1;
  logic                  evr_p1;
  logic                  wr_acc;
  logic                  xfer;
  logic                  load;

  // Explicit wrap so DEPTH need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    if (p == ADDR_WIDTH'(DEPTH - 1)) begin
      return '0;
    end
    return p + ADDR_WIDTH'(1);
  endfunction

  assign full      = (level_q == CNT_WIDTH'(DEPTH));
  assign empty     = (level_q == '0);
  assign wr_acc    = wr_vld & ~full;
  assign xfer      = vld_p1 & rd_rdy;
  // level includes the word held in the output slot; mem_count is RAM only.
  assign mem_count = level_q - CNT_WIDTH'(vld_p1);
  assign load      = drain_en & (mem_count != '0) & (~vld_p1 | rd_rdy);

  sample_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc & rstn & ~clear),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

  // Stage p1: pointers, level and the registered output slot.
  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      ostage_p1 <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      done_p1   <= 1'b0;
      evf_p1    <= 1'b0;
      evr_p1    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      case ({wr_acc, xfer})
        2'b10:   level_q <= level_q + CNT_WIDTH'(1);
        2'b01:   level_q <= level_q - CNT_WIDTH'(1);
        default: level_q <= level_q;
      endcase
      if (load) begin
        rd_ptr    <= ptr_inc(rd_ptr);
        ostage_p1 <= ram_rd_data;
        vld_p1    <= 1'b1;
        // Final word only if the RAM empties with this load and nothing
        // new is landing in the same cycle.
        last_p1   <= (mem_count == CNT_WIDTH'(1)) & ~wr_acc;
      end else if (xfer) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end
      done_p1 <= xfer & last_p1;
      evf_p1  <= wr_vld & full;
      evr_p1  <= rd_rdy & ~drain_en;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      state <= CAPTURE;
    end else begin
      case (state)
        CAPTURE: if (drain_en) state <= DRAIN;
        DRAIN:   if (xfer && last_p1) state <= DONE;
        DONE:    state <= DONE;
        default: state <= CAPTURE;
      endcase
    end
  end

  assign rd_data                        = ostage_p1;
  assign rd_vld                         = vld_p1;
  assign rd_last                        = last_p1;
  assign level                          = level_q;
  assign drain_done                     = done_p1;
  assign event_wr_when_full             = evf_p1;
  assign event_rd_rdy_when_not_draining = evr_p1;

endmodule

// File: doc/sample_capture_buf.md
Name: sample_capture_buf

Overview:
- Capture buffer directly downstream of the measurement system controller.
- Stores every accepted sample (out_data / out_data_vld of the controller) during the execute phase.
- Drains the samples to the firmware readout path over a valid/ready stream once the controller signals finish (finish_op drives drain_en).
- Reports level, full/empty and error events to firmware.

Parameters:
- DEPTH, 1024, number of sample words stored; must equal the controller's FIFO_SIZE.
- DATA_WIDTH, 32, sample width in bits.
- ADDR_WIDTH, $clog2(DEPTH), memory address width.
- CNT_WIDTH, $clog2(DEPTH)+1, level counter width (holds 0..DEPTH).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- clear  in  1  synchronous flush; 1-cycle pulse on restart (REDO/RECONFIG/CLOSE).
- wr_data  in  DATA_WIDTH  sample from controller.
- wr_vld  in  1  sample valid.
- drain_en  in  1  readout permitted (tied to finish_op).
- rd_data  out  DATA_WIDTH  readout sample.
- rd_vld  out  1  readout valid.
- rd_rdy  in  1  firmware ready.
- rd_last  out  1  marks the final stored sample.
- level  out  CNT_WIDTH  words written and not yet handshaked out.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- drain_done  out  1  1-cycle pulse after the last handshake.
- event_wr_when_full  out  1  1-cycle pulse: wr_vld while full.
- event_rd_rdy_when_not_draining  out  1  1-cycle pulse: rd_rdy while drain_en low.

Behaviour:
- Reset (rstn low at posedge) and clear:
  - All pointers, level, state and output register go to 0.
  - rd_vld, rd_last, drain_done and events go to 0; rd_data goes to 0.
  - clear has priority over every same-cycle write or read.
- Storage:
  - Single-port-write / single-port-read RAM array with wr_ptr and rd_ptr (ADDR_WIDTH).
  - Pointers wrap modulo DEPTH. DEPTH need not be a power of two; wrap is explicit at DEPTH-1 -> 0.
- Write:
  - Accepted when wr_vld & ~full: mem[wr_ptr] <= wr_data, wr_ptr++.
  - wr_vld & full: write dropped, no state change, event_wr_when_full pulses next cycle.
- Output stage:
  - One registered output slot (ostage) holding the word presented on rd_data.
  - Load condition: drain_en & (mem_count > 0) & (~rd_vld | rd_rdy).
  - On load: ostage <= mem[rd_ptr], rd_ptr++, rd_vld <= 1 the next cycle.
  - mem_count = words in RAM, excluding ostage.
- Handshake:
  - Transfer occurs when rd_vld & rd_rdy.
  - rd_data and rd_last stay stable while rd_vld & ~rd_rdy.
  - rd_vld never deasserts without a transfer, except on clear or reset.
  - Back-to-back transfers give 1 word/cycle throughput.
- Latency: drain_en rising with level > 0 -> rd_vld high 1 cycle later.
- rd_last: high with rd_vld when mem_count == 0 at ostage load, i.e. the final stored word.
- level:
  - +1 on an accepted write, -1 on a transfer, unchanged on simultaneous write+transfer.
  - Never exceeds DEPTH and never underflows.
- drain_en falling mid-drain:
  - No new loads.
  - A word already in ostage stays presented until transferred.
- drain_done: pulses the cycle after the transfer carrying rd_last.
- State (NUM 3, 2 bits):
  - CAPTURE (reset state). Go to DRAIN when drain_en.
  - DRAIN. Go to DONE on the rd_last transfer.
  - DONE. Go to CAPTURE on clear.
  - Writes are accepted in any state; in DONE with level 0 they are still stored. The controller guarantees none occur.
- Overflow protection: level is saturating by construction; full blocks writes.

Decomposition:
- Shared package holds:
  - State encodings CAPTURE/DRAIN/DONE and width.
  - The restart-type constants shared with the controller (REDO/RECONFIG/CLOSE).
  - DATA_WIDTH default.
- Sub-module: sample_ram (simple dual-port, synchronous write, combinational or registered read). The top holds the pointers, count, output stage and FSM.

Test Plan (DEPTH=8 for directed tests):
- Fill and drain:
  - Write 0x00..0x07 on 8 consecutive cycles -> full=1, level=8.
  - drain_en=1, rd_rdy=1 -> rd_data 0x00..0x07 on 8 consecutive cycles, rd_last only with 0x07, drain_done pulse the next cycle, empty=1.
- Overflow:
  - After full, assert wr_vld with 0xAA -> event_wr_when_full pulses once, level stays 8.
  - Drained data contains no 0xAA.
- Backpressure:
  - Drain with rd_rdy toggling 1,0,0,1… -> rd_data held stable during stalls, order preserved, exactly 8 transfers.
- Simultaneous write/read:
  - Level 3, drain active, wr_vld and transfer in the same cycle -> level remains 3.
  - Pointer wrap past index 7 returns correct data.
- Clear / reset mid-drain:
  - After 3 transfers, pulse clear with rd_vld=1 -> next cycle rd_vld=0, level=0, state CAPTURE.
  - Repeating the test with rstn=0 gives identical results.
- drain_en drop:
  - Deassert drain_en while rd_vld=1, rd_rdy=0 -> word held until rd_rdy.
  - No further loads; rd_rdy while drain_en=0 and rd_vld=0 pulses event_rd_rdy_when_not_draining.
